// File: rtl/dual_ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller wrapped around an external 16x8 dual-address RAM.
// Port 0 of the RAM is written from the write pointer; port 1 is read asynchronously from the read pointer.
module dual_ram_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_wr_en,
    output logic              ram_port_en_0,
    output logic [ADDR_W-1:0] ram_addr_0,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_port_en_1,
    output logic [ADDR_W-1:0] ram_addr_1,
    input  logic [DATA_W-1:0] ram_data_out_1
);

    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_AF   = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   cnt;
    logic              push;
    logic              pop;

    assign full        = (cnt == CNT_FULL);
    assign empty       = (cnt == '0);
    assign almost_full = (cnt >= CNT_AF);
    assign count       = cnt;
    assign wr_ready    = !full;
    assign rd_valid    = !empty;

    // Handshakes are gated on the current occupancy, so a full FIFO pops before it
    // accepts and an empty FIFO pushes before it presents; flush suppresses both.
    assign push = wr_valid && !full && !flush;
    assign pop  = rd_ready && !empty && !flush;

    assign ram_wr_en     = push;
    assign ram_port_en_0 = push;
    assign ram_addr_0    = wptr;
    assign ram_data_in   = wr_data;
    assign ram_port_en_1 = !empty;
    assign ram_addr_1    = rptr;
    assign rd_data       = ram_data_out_1;

    // NOTE: every flop here uses non-blocking assignment so all state samples the
    // pre-edge values of push/pop and of each other, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            if (wr_valid && full)  overflow  <= 1'b1;
            if (rd_ready && empty) underflow <= 1'b1;
        end
    end

    a_not_full_and_empty : assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));
    a_cnt_in_range       : assert property (@(posedge clk) disable iff (!rst_n) cnt <= CNT_FULL);

endmodule
